// File: rtl/prim_ram_1p_arb.sv
// prim_ram_1p_arb: NumPorts requesters share one single-port RAM through a
// round-robin arbiter. Grants are combinational, read data returns one cycle
// after the read grant on a shared bus qualified by a one-hot rvalid.
// Optional post-reset zero sweep: define PRIM_RAM_1P_ARB_INIT_EN.
module prim_ram_1p_arb #(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 2048,
    parameter int unsigned NumPorts = 2,
    localparam int unsigned Aw      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts-1:0]          req_i,
    input  logic [NumPorts-1:0]          write_i,
    input  logic [NumPorts*Aw-1:0]       addr_i,
    input  logic [NumPorts*Width-1:0]    wdata_i,
    input  logic [NumPorts*Width-1:0]    wmask_i,
    output logic [NumPorts-1:0]          gnt_o,
    output logic [NumPorts-1:0]          rvalid_o,
    output logic [Width-1:0]             rdata_o,
    output logic                         init_done_o
);

    localparam int unsigned PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [Aw:0] DepthExt = (Aw + 1)'(Depth);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                state;
    logic                  init_done;
`ifdef PRIM_RAM_1P_ARB_INIT_EN
    logic [Aw-1:0]         init_addr;
`endif

    logic [PtrW-1:0]       ptr;
    logic [NumPorts-1:0]   gnt;
    logic                  gnt_any;
    logic [PtrW-1:0]       sel;

    logic                  ch_write;
    logic [Aw-1:0]         ch_addr;
    logic [Width-1:0]      ch_wdata;
    logic [Width-1:0]      ch_wmask;
    logic                  ch_in_range;
    logic                  rd_fire;

    logic                  mem_we;
    logic [Aw-1:0]         mem_waddr;
    logic [Width-1:0]      mem_wdata;
    logic [Width-1:0]      mem_wmask;

    logic [Width-1:0]      mem [Depth];
    logic [NumPorts-1:0]   rvalid;
    logic [Width-1:0]      rdata;

    // Round-robin pick: the requester with the smallest wrapped distance from the pointer.
    // Distance form keeps every index a constant loop variable.
    always_comb begin
        int unsigned best_d;
        int unsigned best_k;
        int unsigned d;
        gnt     = '0;
        gnt_any = 1'b0;
        sel     = '0;
        best_d  = NumPorts;
        best_k  = 0;
        d       = 0;
        if (init_done) begin
            for (int unsigned k = 0; k < NumPorts; k++) begin
                if (req_i[k]) begin
                    d = (k >= 32'(ptr)) ? (k - 32'(ptr)) : (k + NumPorts - 32'(ptr));
                    if (d < best_d) begin
                        best_d = d;
                        best_k = k;
                    end
                end
            end
            if (best_d < NumPorts) begin
                gnt_any = 1'b1;
                sel     = PtrW'(best_k);
                for (int unsigned k = 0; k < NumPorts; k++) begin
                    if (k == best_k) begin
                        gnt[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Route the granted channel's request fields onto the memory port.
    always_comb begin
        ch_write = 1'b0;
        ch_addr  = '0;
        ch_wdata = '0;
        ch_wmask = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (gnt[k]) begin
                ch_write = write_i[k];
                ch_addr  = addr_i[k*Aw +: Aw];
                ch_wdata = wdata_i[k*Width +: Width];
                ch_wmask = wmask_i[k*Width +: Width];
            end
        end
        ch_in_range = ({1'b0, ch_addr} < DepthExt);
        rd_fire     = gnt_any & ~ch_write;
    end

    // Memory write port: the zero sweep owns it during INIT, otherwise the granted write.
    always_comb begin
        mem_we    = gnt_any & ch_write & ch_in_range;
        mem_waddr = ch_addr;
        mem_wdata = ch_wdata;
        mem_wmask = ch_wmask;
`ifdef PRIM_RAM_1P_ARB_INIT_EN
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = '0;
            mem_wmask = '1;
        end
`endif
    end

    // Bit-masked write into the array; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    // Read return: one-cycle rvalid pulse to the granted reader, data held between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt & {NumPorts{rd_fire}};
            if (rd_fire) begin
                rdata <= ch_in_range ? mem[ch_addr] : '0;
            end
        end
    end

    // Pointer advances past the granted channel, wrapping at NumPorts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (sel == PtrW'(NumPorts - 1)) ? '0 : sel + 1'b1;
        end
    end

    // Startup FSM: INIT (optional zero sweep) then READY, init_done registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_INIT;
            init_done <= 1'b0;
`ifdef PRIM_RAM_1P_ARB_INIT_EN
            init_addr <= '0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
`ifdef PRIM_RAM_1P_ARB_INIT_EN
                    if (init_addr == Aw'(Depth - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
`else
                    state     <= ST_READY;
                    init_done <= 1'b1;
`endif
                end
                ST_READY: begin
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    assign gnt_o       = gnt;
    assign rvalid_o    = rvalid;
    assign rdata_o     = rdata;
    assign init_done_o = init_done;

endmodule

// File: doc/prim_ram_1p_arb.md
Name: prim_ram_1p_arb

Overview:
- Parametrised successor to the team's single-port RAM primitive.
- NumPorts independent requesters share one behavioural single-port memory array through a round-robin arbiter.
- Per-channel grant and read-valid are provided, with an optional post-reset zero-initialisation sweep.
- Used wherever several masters (e.g. DMA plus core) need one scratch RAM without an external arbiter.

Parameters:
- Width, 32: data word width in bits.
- Depth, 2048: number of words; need not be a power of two.
- NumPorts, 2: number of requesting channels, range 1..8.
- Aw, $clog2(Depth): derived localparam, address width.

Ports:
- clk_i  input  1  clock, all state rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  NumPorts  per-channel request.
- write_i  input  NumPorts  per-channel write (1) / read (0).
- addr_i  input  NumPorts*Aw  per-channel word address; channel k at [k*Aw +: Aw].
- wdata_i  input  NumPorts*Width  per-channel write data.
- wmask_i  input  NumPorts*Width  per-channel bit-level write enable.
- gnt_o  output  NumPorts  one-hot grant, combinational, same cycle as req.
- rvalid_o  output  NumPorts  one-hot read-data valid, one cycle after the read grant.
- rdata_o  output  Width  shared read data, qualified by rvalid_o.
- init_done_o  output  1  high when the memory accepts requests.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0 while rst_i is high. Arbitration pointer resets to channel 0.
- Memory contents are not reset, unless the optional feature is enabled.
- Arbitration: while init_done_o=1, at most one gnt_o bit is high per cycle, always the requesting channel nearest at or after the pointer (wrapping modulo NumPorts).
- Pointer update: on any grant, the pointer moves to granted index+1, wrapping to 0.
- No grant means the pointer is unchanged. gnt_o never asserts for a channel whose req_i is low.
- Handshake: a requester holds req/write/addr/wdata/wmask stable until gnt_o. The transfer occurs in the grant cycle.
- Write: for each bit b with wmask[b]=1, mem[addr][b] <= wdata[b]; other bits are unchanged. No rvalid for writes.
- Read: rvalid_o[k] pulses exactly one cycle after the read grant to channel k. rdata_o = mem[addr] sampled at the grant edge.
- rdata_o holds its last read value when no rvalid is asserted.
- Back-to-back: a write granted in cycle n followed by a read of the same address granted in n+1 returns the new data in n+2.
- Full throughput: one access per cycle.
- Out-of-range address (addr >= Depth): the access is still granted; the write is dropped; the read returns all-zero with normal rvalid timing.
- Reset mid-operation: any pending rvalid is cancelled (no pulse after rst_i release). The pointer returns to 0.
- NumPorts=1: the arbiter degenerates to gnt_o = req_i & init_done_o.

Optional Feature:
- Macro: PRIM_RAM_1P_ARB_INIT_EN.
- Defined: after rst_i deasserts, FSM states are INIT then READY.
- INIT writes all-zero to address 0..Depth-1, one word per cycle, taking Depth cycles. During INIT, gnt_o=0 and requests are held off.
- init_done_o rises in the cycle after the last address is written. Reset during INIT restarts the sweep at address 0.
- Undefined: no sweep. init_done_o goes 1 on the first clock edge after rst_i deasserts. Memory starts uninitialised (X in simulation).

Test Plan:
- Single-channel write then read: ch0 writes 0xDEADBEEF to addr 5 with mask 0xFFFFFFFF, then reads addr 5 -> gnt_o=01 in both cycles; rvalid_o=01 one cycle after the read grant; rdata_o=0xDEADBEEF.
- Masked write: after the above, ch1 writes 0x12345678 to addr 5 with mask 0x0000FFFF, then reads -> rdata_o=0xDEAD5678, rvalid_o=10.
- Round-robin fairness: NumPorts=3, all req_i held high as reads for 6 cycles -> grant order ch0,ch1,ch2,ch0,ch1,ch2. rvalid_o follows the same order, delayed one cycle.
- Out-of-range: Depth=2000, write to addr 2047 then read it -> write ignored, rdata_o=0, rvalid asserted. Addr 1999 is still unaffected.
- Reset mid-read: ch1 read granted, rst_i pulsed before the next edge -> rvalid_o stays 0, rdata_o=0, the next grant goes to ch0 when both request.
- With PRIM_RAM_1P_ARB_INIT_EN and Depth=16: release reset -> gnt_o=0 for 16 cycles, init_done_o rises on cycle 17, a read of any address returns 0.
